// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, byte held on ascii_out
// between frames, with one-cycle valid / framing-error strobes.
module uart_rx_byte #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t        state, state_next;
  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    out_next;
  logic          valid_next, err_next;

  // Synchroniser resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shift_reg   <= 8'h00;
      ascii_out   <= 8'h00;
      ascii_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      shift_reg   <= shift_next;
      ascii_out   <= out_next;
      ascii_valid <= valid_next;
      frame_err   <= err_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    out_next     = ascii_out;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next = '0;
          // Still low at mid start bit: a real frame; otherwise a glitch.
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next            = '0;
          shift_next[bit_idx] = rx_s;
          if (bit_idx == 3'd7) state_next = STOP;
          else bit_idx_next = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            out_next   = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      BREAK: begin
        // Need a full bit time of continuous idle before hunting for a new start bit.
        if (!rx_s) begin
          cnt_next = '0;
        end else if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 10 clocks per bit; a negedge monitor
// scoreboards received bytes and their latency from the driven start edge.
module tb_uart_rx_byte;

  localparam int CPB = 10;
  localparam int LAT = 98;  // pin edge to ascii_valid: 2 sync + 1 detect + 95

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [7:0] ascii_out;
  logic       ascii_valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_overlap = 0;
  int err_cyc = -1;

  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_rx_byte #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx(rx),
    .ascii_out(ascii_out),
    .ascii_valid(ascii_valid),
    .frame_err(frame_err),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every valid strobe must match the oldest expected byte and its start time.
  always @(negedge clk) begin
    if (ascii_valid && frame_err) n_overlap++;
    if (ascii_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'(exp_q.size()), 32'd1);
      end else begin
        check_eq("byte", {24'h0, ascii_out}, {24'h0, exp_q.pop_front()});
        check_eq("latency", 32'(cyc - start_q.pop_front()), 32'(LAT));
      end
    end
    if (frame_err) begin
      n_err++;
      err_cyc = cyc;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
    if (stop_v) begin
      exp_q.push_back(b);
      start_q.push_back(cyc);
    end
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = stop_v;
    wait_cycles(stop_len);
  endtask

  initial begin
    int p;
    logic [7:0] seq [5];
    logic [7:0] part;
    seq[0] = 8'h30; seq[1] = 8'h39; seq[2] = 8'h41; seq[3] = 8'h53; seq[4] = 8'h44;

    // Reset state with an idle line
    rx = 1'b1;
    reset_n = 1'b0;
    #22;
    check_eq("rst_ascii_out", {24'h0, ascii_out}, 32'h00);
    check_eq("rst_busy", {31'h0, busy}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    wait_cycles(50);
    check_eq("idle_ascii_out", {24'h0, ascii_out}, 32'h00);
    check_eq("idle_valid", {31'h0, ascii_valid}, 32'd0);
    check_eq("idle_frame_err", {31'h0, frame_err}, 32'd0);
    check_eq("idle_busy", {31'h0, busy}, 32'd0);
    check_eq("idle_state", {29'h0, state_dbg}, 32'd0);
    check_eq("idle_no_pulses", 32'(n_valid + n_err), 32'd0);

    // Single 'W'
    send_frame(8'h57, 1'b1, CPB);
    wait_cycles(20);
    check_eq("w_count", 32'(n_valid), 32'd1);
    check_eq("w_ascii_out", {24'h0, ascii_out}, 32'h57);
    check_eq("w_busy", {31'h0, busy}, 32'd0);
    check_eq("w_no_err", 32'(n_err), 32'd0);

    // Back-to-back "09ASD", no idle gap
    for (int i = 0; i < 5; i++) send_frame(seq[i], 1'b1, CPB);
    wait_cycles(20);
    check_eq("b2b_count", 32'(n_valid), 32'd6);
    check_eq("b2b_last", {24'h0, ascii_out}, 32'h44);
    check_eq("b2b_drained", 32'(exp_q.size()), 32'd0);

    // 3-cycle low glitch is rejected by START
    p = cyc;
    rx = 1'b0;
    wait_cycles(3);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("glitch_busy_hi", {31'h0, busy}, 32'd1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check_eq("glitch_cyc", 32'(cyc - p), 32'd12);
    check_eq("glitch_busy_lo", {31'h0, busy}, 32'd0);
    check_eq("glitch_state", {29'h0, state_dbg}, 32'd0);
    @(posedge clk); #1;
    check_eq("glitch_no_pulses", 32'(n_valid + n_err), 32'd6);

    // Good 'W' then 0x44 with bad stop, line held low, then BREAK recovery
    send_frame(8'h57, 1'b1, CPB);
    wait_cycles(5);
    p = cyc;
    send_frame(8'h44, 1'b0, 50);
    check_eq("ferr_count", 32'(n_err), 32'd1);
    check_eq("ferr_latency", 32'(err_cyc - p), 32'(LAT));
    check_eq("ferr_ascii_held", {24'h0, ascii_out}, 32'h57);
    check_eq("ferr_state_break", {29'h0, state_dbg}, 32'd4);
    rx = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    check_eq("break_still", {29'h0, state_dbg}, 32'd4);
    @(posedge clk);
    @(negedge clk);
    check_eq("break_exit", {29'h0, state_dbg}, 32'd0);
    @(posedge clk); #1;
    wait_cycles(30);
    check_eq("break_no_more", 32'(n_valid * 16 + n_err), 32'(7 * 16 + 1));
    check_eq("break_busy", {31'h0, busy}, 32'd0);

    // Reset during bit 4 of 0x53, then a clean 0x31
    part = 8'h53;
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 5; i++) begin
      rx = part[i];
      wait_cycles(i == 4 ? 5 : CPB);
    end
    check_eq("mid_busy_pre", {31'h0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_ascii", {24'h0, ascii_out}, 32'h00);
    check_eq("mid_rst_busy", {31'h0, busy}, 32'd0);
    check_eq("mid_rst_valid", {31'h0, ascii_valid}, 32'd0);
    check_eq("mid_rst_err", {31'h0, frame_err}, 32'd0);
    rx = 1'b1;
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(20);
    check_eq("post_rst_quiet", 32'(n_valid * 16 + n_err), 32'(7 * 16 + 1));
    send_frame(8'h31, 1'b1, CPB);
    wait_cycles(20);
    check_eq("post_rst_byte", {24'h0, ascii_out}, 32'h31);
    check_eq("final_valid", 32'(n_valid), 32'd8);
    check_eq("final_err", 32'(n_err), 32'd1);
    check_eq("final_overlap", 32'(n_overlap), 32'd0);
    check_eq("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Serial receiver for the chess board's PC/terminal link, directly upstream of the ASCII-to-hex key decoder. It recovers 8N1 UART frames from the asynchronous rx pin and presents each byte on ascii_out with a one-cycle ascii_valid strobe. ascii_out drives the decoder's 8-bit ASCII input. The byte is held between frames so the combinational decoder output stays stable.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, truncated), must be >= 4
HALF_BIT, CLKS_PER_BIT/2, derived; mid-bit sampling offset

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
rx  input  1  raw UART line, idle high, asynchronous to clk
ascii_out  output  8  last correctly received byte, LSB first on the wire
ascii_valid  output  1  one-cycle pulse: ascii_out just updated
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high while a frame is in progress (state not IDLE)

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, ascii_out=8'h00, ascii_valid=0, frame_err=0, busy=0, bit counter=0, baud counter=0, both synchroniser flops=1 (idle level).
- rx passes through a 2-flop synchroniser; rx_s is the 2nd flop output. All decisions use rx_s only.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: baud counter held at 0. rx_s==0 -> START, counter cleared.
- START: count to HALF_BIT-1. At that cycle sample rx_s: 0 -> DATA, counter=0, bit index=0; 1 -> glitch, back to IDLE, no pulses.
- DATA: count 0..CLKS_PER_BIT-1; at CLKS_PER_BIT-1 shift rx_s into shift register bit [index] (LSB first), counter=0. After index 7 sampled -> STOP.
- STOP: at CLKS_PER_BIT-1 sample rx_s. 1 -> ascii_out<=shift register, ascii_valid=1 next cycle, -> IDLE. 0 -> frame_err=1 next cycle, ascii_out unchanged, -> BREAK.
- BREAK: wait until rx_s has been 1 for CLKS_PER_BIT consecutive cycles (counter resets on any 0), then -> IDLE. Prevents a held-low line from producing repeated frames.
- ascii_valid and frame_err are never high together and each is high for exactly one clk cycle per frame.
- Latency: stop sample occurs HALF_BIT + 9*CLKS_PER_BIT cycles after the first cycle rx_s==0 in IDLE; ascii_valid is high on the following cycle. With the synchroniser, that is +2 cycles from the rx pin edge.
- Back-to-back frames: a start bit beginning immediately after the stop sample is accepted. IDLE detects it on the first rx_s==0 cycle.
- busy=1 in START, DATA, STOP, BREAK; 0 in IDLE.
- Reset asserted mid-frame aborts immediately. No pulse is emitted, and ascii_out returns to 8'h00.

Test Plan:
- Params CLK_FREQ=1000, BAUD=100 (CLKS_PER_BIT=10, HALF_BIT=5). Send 0x57 'W' 8N1 -> ascii_valid single pulse, ascii_out=8'h57, frame_err never high, busy 0 after.
- Send '0','9','A','S','D' back-to-back, with no idle gap -> five ascii_valid pulses, ascii_out sequence 30,39,41,53,44. Each pulse arrives exactly 95 cycles after its start-edge detect +1.
- rx low pulse of 3 cycles, then high -> START rejects it. No ascii_valid, no frame_err, busy returns to 0 within 6 cycles.
- Frame 0x44 with stop bit driven 0, then line held low 40 cycles, then high -> one frame_err pulse and ascii_out keeps its previous value. State stays BREAK until 10 high cycles, and no further pulses occur.
- Assert reset_n low during bit 4 of 0x53 -> outputs go to reset values asynchronously. After release with an idle line, the next full 0x31 frame yields ascii_out=8'h31.
- Reset value check: immediately after reset, ascii_out=00, ascii_valid=0, frame_err=0, busy=0 with rx held high indefinitely.
